// File: rtl/hilo_unit_pkg.sv
// Shared types for the HI/LO unit: execute-stage op encodings, FSM states and
// the divider iteration count.
package hilo_unit_pkg;

   typedef enum logic [2:0] {
      HILO_OP_NONE  = 3'd0,
      HILO_OP_MULT  = 3'd1,
      HILO_OP_MULTU = 3'd2,
      HILO_OP_DIV   = 3'd3,
      HILO_OP_DIVU  = 3'd4,
      HILO_OP_MTHI  = 3'd5,
      HILO_OP_MTLO  = 3'd6,
      HILO_OP_RSVD  = 3'd7
   } hilo_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } hilo_state_e;

   localparam int unsigned DIV_ITERS_DEFAULT = 32;

   function automatic logic is_div_op(input hilo_op_e op);
      return (op == HILO_OP_DIV) || (op == HILO_OP_DIVU);
   endfunction

endpackage

// File: rtl/hilo_unit_div_core.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes, with
// sign correction applied to the held results.
module div_core
   import hilo_unit_pkg::*;
#(
   parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic        signed_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        done
);

   localparam int unsigned CW = $clog2(DIV_ITERS);

   logic [CW-1:0] count_q;
   logic          running_q;
   logic [31:0]   rem_q;
   logic [31:0]   quo_q;
   logic [31:0]   dvs_q;
   logic          neg_quo_q;
   logic          neg_rem_q;

   logic [32:0]   rem_sh;
   logic [32:0]   diff;
   logic [31:0]   dvd_abs;
   logic [31:0]   dvs_abs;

   assign dvd_abs = (signed_op && dividend[31]) ? -dividend : dividend;
   assign dvs_abs = (signed_op && divisor[31])  ? -divisor  : divisor;

   // quo_q starts as the dividend and shifts quotient bits in from the bottom
   assign rem_sh = {rem_q, quo_q[31]};
   assign diff   = rem_sh - {1'b0, dvs_q};

   assign done      = running_q && (count_q == CW'(DIV_ITERS - 1));
   assign quotient  = neg_quo_q ? -quo_q : quo_q;
   assign remainder = neg_rem_q ? -rem_q : rem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         running_q <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (flush) begin
         count_q   <= '0;
         running_q <= 1'b0;
      end else if (start) begin
         count_q <= '0;
         if (divisor == '0) begin
            // divide by zero: results are ready immediately, no iterations
            running_q <= 1'b0;
            quo_q     <= '1;
            rem_q     <= dividend;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
         end else begin
            running_q <= 1'b1;
            quo_q     <= dvd_abs;
            rem_q     <= '0;
            dvs_q     <= dvs_abs;
            neg_quo_q <= signed_op && (dividend[31] ^ divisor[31]);
            neg_rem_q <= signed_op && dividend[31];
         end
      end else if (running_q) begin
         quo_q   <= {quo_q[30:0], ~diff[32]};
         rem_q   <= diff[32] ? rem_sh[31:0] : diff[31:0];
         count_q <= count_q + 1'b1;
         if (done) running_q <= 1'b0;
      end
   end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register file beside the execute stage: single-cycle multiply and
// moves, multi-cycle divide that stalls the pipeline while it runs.
module hilo_unit
   import hilo_unit_pkg::*;
#(
   parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  hilo_op,
   input  logic [31:0] rdata1,
   input  logic [31:0] rdata2,
   input  logic        flush,
   output logic [31:0] hi_data,
   output logic [31:0] lo_data,
   output logic        stall_req,
   output logic        busy
);

   hilo_state_e state_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        busy_q;

   hilo_op_e    op;
   logic        div_start;
   logic [63:0] prod_s_d;
   logic [63:0] prod_u_d;
   logic [31:0] quo;
   logic [31:0] rem;
   logic        div_done;

   assign op        = hilo_op_e'(hilo_op);
   assign div_start = (state_q == ST_IDLE) && is_div_op(op) && !flush && !rst;

   assign prod_s_d = {{32{rdata1[31]}}, rdata1} * {{32{rdata2[31]}}, rdata2};
   assign prod_u_d = {32'b0, rdata1} * {32'b0, rdata2};

   always_comb begin
      stall_req = 1'b0;
      if (!rst && !flush) begin
         stall_req = (state_q == ST_DIV) ||
                     ((state_q == ST_IDLE) && is_div_op(op));
      end
   end

   div_core #(
      .DIV_ITERS (DIV_ITERS)
   ) u_div_core (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .flush     (flush),
      .signed_op (op == HILO_OP_DIV),
      .dividend  (rdata1),
      .divisor   (rdata2),
      .quotient  (quo),
      .remainder (rem),
      .done      (div_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else if (flush) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               case (op)
                  HILO_OP_MULT:  {hi_q, lo_q} <= prod_s_d;
                  HILO_OP_MULTU: {hi_q, lo_q} <= prod_u_d;
                  HILO_OP_MTHI:  hi_q <= rdata1;
                  HILO_OP_MTLO:  lo_q <= rdata1;
                  HILO_OP_DIV, HILO_OP_DIVU: begin
                     if (rdata2 == '0) begin
                        state_q <= ST_DONE;
                     end else begin
                        state_q <= ST_DIV;
                        busy_q  <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            ST_DIV: begin
               if (div_done) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
               end
            end
            ST_DONE: begin
               // the op still held by the stalled upstream is ignored here
               hi_q    <= rem;
               lo_q    <= quo;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign hi_data = hi_q;
   assign lo_data = lo_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: the driver queues expected HI/LO and
// stall/busy values per cycle, a negedge monitor pops and compares them.
module tb_hilo_unit;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  hilo_op = OP_NONE;
   logic [31:0] rdata1 = '0;
   logic [31:0] rdata2 = '0;
   logic        flush = 1'b0;
   logic [31:0] hi_data;
   logic [31:0] lo_data;
   logic        stall_req;
   logic        busy;

   hilo_unit #(.DIV_ITERS(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .hilo_op   (hilo_op),
      .rdata1    (rdata1),
      .rdata2    (rdata2),
      .flush     (flush),
      .hi_data   (hi_data),
      .lo_data   (lo_data),
      .stall_req (stall_req),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int unsigned cyc;
      bit          is_hilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        stall;
      logic        busy;
   } exp_t;

   exp_t exp_q[$];
   int unsigned checks = 0;
   int unsigned passes = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   function automatic void chk(input string nm, input int unsigned c,
                               input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, got, want);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         if (e.cyc < cyc) begin
            checks++;
            $display("FAIL stale_expect cyc=%0d got=%0d want=%0d", e.cyc, cyc, e.cyc);
         end else if (e.is_hilo) begin
            chk("hi", e.cyc, hi_data, e.hi);
            chk("lo", e.cyc, lo_data, e.lo);
         end else begin
            chk("stall_req", e.cyc, {31'b0, stall_req}, {31'b0, e.stall});
            chk("busy", e.cyc, {31'b0, busy}, {31'b0, e.busy});
         end
      end
   end

   function automatic void push_ctl(input int unsigned c, input logic s, input logic b);
      exp_t e;
      e.cyc = c; e.is_hilo = 1'b0; e.hi = '0; e.lo = '0; e.stall = s; e.busy = b;
      exp_q.push_back(e);
   endfunction

   function automatic void push_hilo(input int unsigned c);
      exp_t e;
      e.cyc = c; e.is_hilo = 1'b1; e.hi = m_hi; e.lo = m_lo; e.stall = 1'b0; e.busy = 1'b0;
      exp_q.push_back(e);
   endfunction

   // Reference model from the architectural definition of each op.
   function automatic void model_op(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
      longint          sp, sq, sr;
      longint unsigned up;
      case (op)
         OP_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            m_hi = sp[63:32]; m_lo = sp[31:0];
         end
         OP_MULTU: begin
            up = longint'({32'b0, a}) * longint'({32'b0, b});
            m_hi = up[63:32]; m_lo = up[31:0];
         end
         OP_DIV: begin
            if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
            else begin
               sq = longint'($signed(a)) / longint'($signed(b));
               sr = longint'($signed(a)) % longint'($signed(b));
               m_lo = sq[31:0]; m_hi = sr[31:0];
            end
         end
         OP_DIVU: begin
            if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
         end
         OP_MTHI: m_hi = a;
         OP_MTLO: m_lo = a;
         default: ;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_single(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit fl);
      int unsigned t = cyc;
      hilo_op = op; rdata1 = a; rdata2 = b; flush = fl;
      push_ctl(t, 1'b0, 1'b0);
      if (!fl) model_op(op, a, b);
      push_hilo(t + 1);
      step();
      hilo_op = OP_NONE; flush = 1'b0;
   endtask

   // abort_at: cycle offset for flush/reset (0 = none); abort_rst selects reset.
   task automatic issue_div(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int unsigned abort_at,
                            input bit abort_rst);
      int unsigned t = cyc;
      hilo_op = op; rdata1 = a; rdata2 = b;
      if (b == 0) begin
         push_ctl(t, 1'b1, 1'b0);
         step();
         push_ctl(t + 1, 1'b0, 1'b0);
         model_op(op, a, b);
         step();
         push_hilo(t + 2);
         hilo_op = OP_NONE;
         return;
      end
      for (int unsigned i = 0; i <= 33; i++) begin
         if (abort_at != 0 && i == abort_at) begin
            if (abort_rst) rst = 1'b1; else flush = 1'b1;
            push_ctl(t + i, 1'b0, (i >= 1 && i <= 32));
            step();
            rst = 1'b0; flush = 1'b0; hilo_op = OP_NONE;
            if (abort_rst) begin m_hi = '0; m_lo = '0; end
            push_hilo(t + i + 1);
            push_ctl(t + i + 1, 1'b0, 1'b0);
            return;
         end
         push_ctl(t + i, (i <= 32), (i >= 1 && i <= 32));
         step();
      end
      model_op(op, a, b);
      push_hilo(t + 34);
      hilo_op = OP_NONE;
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int unsigned wait_cyc;

      step();
      step();
      rst = 1'b0;
      push_ctl(cyc, 1'b0, 1'b0);
      push_hilo(cyc);

      issue_single(OP_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0);
      issue_single(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      issue_single(OP_MTHI,  32'h1234_5678, 32'd0, 1'b0);
      issue_single(OP_MTLO,  32'h9ABC_DEF0, 32'd0, 1'b0);
      issue_div(OP_DIV,  32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      issue_div(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 0, 1'b0);
      issue_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      issue_div(OP_DIV,  32'd5, 32'd0, 0, 1'b0);
      issue_div(OP_DIVU, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);
      issue_single(OP_MTHI, 32'hCAFE_0001, 32'd0, 1'b0);
      issue_div(OP_DIV,  32'd100, 32'd3, 10, 1'b0);
      issue_single(OP_MULT, 32'd7, 32'd9, 1'b1);
      issue_div(OP_DIV,  32'd100, 32'd3, 0, 1'b0);
      issue_div(OP_DIV,  32'd100, 32'd3, 10, 1'b1);
      issue_single(OP_MTLO, 32'h0BAD_F00D, 32'd0, 1'b0);

      for (int unsigned n = 0; n < 40; n++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = 32'($urandom_range(1, 15));
            2: a = 32'h8000_0000;
            default: ;
         endcase
         if (op == OP_DIV || op == OP_DIVU) issue_div(op, a, b, 0, 1'b0);
         else issue_single(op, a, b, ($urandom_range(0, 9) == 0));
      end

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 50) begin
         step();
         wait_cyc++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain got=%0d want=0 pending expectations", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
